// File: rtl/rf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_sched
// Description : Writeback arbiter and pending-write scoreboard. Two writeback
//               requesters (ALU and load unit) share one register-file write
//               port under round-robin arbitration. A 32-entry busy vector
//               tracks outstanding writes and stalls issue on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  iss_ra1,
    input  logic [4:0]  iss_ra2,
    output logic        iss_stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_wa,
    input  logic [31:0] alu_wd,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_wd,
    output logic        mem_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] busy
);

    localparam logic [4:0] C_X0 = 5'd0;

    logic        r_last_mem;   // 1: the load unit was granted most recently
    logic        r_we;
    logic [4:0]  r_wa;
    logic [31:0] r_wd;
    logic [31:0] r_busy;

    logic        w_alu_xfer;
    logic        w_mem_xfer;
    logic        w_xfer;
    logic [4:0]  w_xfer_wa;
    logic [31:0] w_xfer_wd;
    logic [31:0] w_eb;
    logic        w_issue;
    logic [31:0] w_busy_next;

    // A write landing while reset is high is suppressed so nothing in flight
    // reaches the register file.
    assign rf_we = r_we & ~rst;
    assign rf_wa = r_wa;
    assign rf_wd = r_wd;
    assign busy  = r_busy;

    // Round-robin grant: depends only on the valids and the pointer.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            alu_ready = alu_valid & (~mem_valid | r_last_mem);
            mem_ready = mem_valid & (~alu_valid | ~r_last_mem);
        end
    end

    assign w_alu_xfer = alu_valid & alu_ready;
    assign w_mem_xfer = mem_valid & mem_ready;
    assign w_xfer     = w_alu_xfer | w_mem_xfer;
    assign w_xfer_wa  = w_alu_xfer ? alu_wa : mem_wa;
    assign w_xfer_wd  = w_alu_xfer ? alu_wd : mem_wd;

    // Effective busy: a register being written this cycle is forwarded by the
    // register file, so it no longer blocks issue.
    always_comb begin
        w_eb = r_busy;
        if (rf_we) begin
            w_eb[rf_wa] = 1'b0;
        end
    end

    // Hazard check over both sources (RAW) and the destination (WAW).
    always_comb begin
        iss_stall = 1'b0;
        if (!rst && iss_valid) begin
            iss_stall = ((iss_ra1 != C_X0) && w_eb[iss_ra1]) ||
                        ((iss_ra2 != C_X0) && w_eb[iss_ra2]) ||
                        ((iss_rd  != C_X0) && w_eb[iss_rd]);
        end
    end

    assign w_issue = ~rst & iss_valid & ~iss_stall;

    // Scoreboard update: clear on writeback, then set on issue so set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (rf_we) begin
            w_busy_next[rf_wa] = 1'b0;
        end
        if (w_issue && (iss_rd != C_X0)) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // State registers: pointer, write-port pipeline stage and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mem <= 1'b1;
            r_we       <= 1'b0;
            r_wa       <= 5'd0;
            r_wd       <= 32'd0;
            r_busy     <= 32'd0;
        end else begin
            if (w_xfer) begin
                r_last_mem <= w_mem_xfer;
                r_wa       <= w_xfer_wa;
                r_wd       <= w_xfer_wd;
            end
            r_we   <= w_xfer && (w_xfer_wa != C_X0);
            r_busy <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_sched
// Description : Self-checking bench for rf_wb_sched: directed scenarios plus
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd, iss_ra1, iss_ra2;
    logic        iss_stall;
    logic        alu_valid;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    bit        m_busy [32];
    bit        m_last_mem;   // which requester won most recently
    bit        m_we;
    int        m_wa;
    bit [31:0] m_wd;

    rf_wb_sched dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ra1(iss_ra1), .iss_ra2(iss_ra2),
        .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic bit m_wr_now();
        return m_we && !rst;
    endfunction

    function automatic bit m_eb(input int r);
        return m_busy[r] && !(m_wr_now() && m_wa == r);
    endfunction

    // One clock cycle: check DUT against model, then advance model past the edge.
    task automatic step();
        bit e_stall, g_alu, g_mem, wr, acc;
        #2;
        wr = m_wr_now();
        e_stall = !rst && iss_valid &&
                  ((iss_ra1 != 0 && m_eb(iss_ra1)) || (iss_ra2 != 0 && m_eb(iss_ra2)) ||
                   (iss_rd != 0 && m_eb(iss_rd)));
        g_alu = 0; g_mem = 0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (m_last_mem) g_alu = 1; else g_mem = 1;
            end else begin
                g_alu = alu_valid;
                g_mem = mem_valid;
            end
        end
        chk("busy", busy, m_busy_vec());
        chk("rf_we", {31'd0, rf_we}, {31'd0, wr});
        if (wr) begin
            chk("rf_wa", {27'd0, rf_wa}, m_wa[31:0]);
            chk("rf_wd", rf_wd, m_wd);
        end
        chk("iss_stall", {31'd0, iss_stall}, {31'd0, e_stall});
        chk("alu_grant", {31'd0, alu_valid & alu_ready}, {31'd0, g_alu});
        chk("mem_grant", {31'd0, mem_valid & mem_ready}, {31'd0, g_mem});
        acc = !rst && iss_valid && !e_stall;
        @(posedge clk);
        if (rst) begin
            foreach (m_busy[r]) m_busy[r] = 0;
            m_last_mem = 1; m_we = 0; m_wa = 0; m_wd = 0;
        end else begin
            if (wr) m_busy[m_wa] = 0;
            if (acc && iss_rd != 0) m_busy[iss_rd] = 1;
            m_busy[0] = 0;
            m_we = 0;
            if (g_alu) begin
                m_last_mem = 0; m_wa = alu_wa; m_wd = alu_wd; m_we = (alu_wa != 0);
            end else if (g_mem) begin
                m_last_mem = 1; m_wa = mem_wa; m_wd = mem_wd; m_we = (mem_wa != 0);
            end
        end
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rd = 0; iss_ra1 = 0; iss_ra2 = 0;
        alu_valid = 0; alu_wa = 0; alu_wd = 0;
        mem_valid = 0; mem_wa = 0; mem_wd = 0;
    endtask

    initial begin
        foreach (m_busy[r]) m_busy[r] = 0;
        m_last_mem = 1; m_we = 0; m_wa = 0; m_wd = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;

        // Reset: outputs cleared, no grant even with requests pending
        alu_valid = 1; alu_wa = 4; alu_wd = 32'h55; iss_valid = 1; iss_ra1 = 1;
        step(); step();
        chk("rst_busy", busy, 32'd0);
        chk("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        idle(); rst = 0;

        // Issue rd=5, load unit writes x5
        iss_valid = 1; iss_rd = 5; step(); idle();
        chk("s1_busy5_set", {31'd0, busy[5]}, 32'd1);
        mem_valid = 1; mem_wa = 5; mem_wd = 32'hDEADBEEF; step(); idle();
        chk("s1_we", {31'd0, rf_we}, 32'd1);
        chk("s1_wa", {27'd0, rf_wa}, 32'd5);
        chk("s1_wd", rf_wd, 32'hDEADBEEF);
        step();
        chk("s1_busy5_clr", {31'd0, busy[5]}, 32'd0);

        // RAW stall on x7 until its writeback appears
        iss_valid = 1; iss_rd = 7; step(); idle();
        iss_valid = 1; iss_ra1 = 7; step(); step();
        #1 chk("s2_stall", {31'd0, iss_stall}, 32'd1);
        alu_valid = 1; alu_wa = 7; alu_wd = 32'h77; step(); alu_valid = 0;
        #1 chk("s2_release", {31'd0, iss_stall}, 32'd0);
        step(); idle();

        // Both requesters contend after reset: ALU, MEM, ALU, MEM
        rst = 1; step(); rst = 0;
        alu_valid = 1; alu_wa = 1; alu_wd = 32'hA1;
        mem_valid = 1; mem_wa = 2; mem_wd = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s3_rr_wa", {27'd0, rf_wa}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle(); step();

        // Same-cycle clear and set of x3: set wins
        iss_valid = 1; iss_rd = 3; step(); idle();
        alu_valid = 1; alu_wa = 3; alu_wd = 32'h33; step(); idle();
        iss_valid = 1; iss_rd = 3; step(); idle();
        chk("s4_busy3", {31'd0, busy[3]}, 32'd1);

        // Write to x0 is dropped
        alu_valid = 1; alu_wa = 0; alu_wd = 32'h1234; step(); idle();
        chk("s5_we0", {31'd0, rf_we}, 32'd0);
        chk("s5_busy0", {31'd0, busy[0]}, 32'd0);

        // Reset right after a transfer discards it
        alu_valid = 1; alu_wa = 9; alu_wd = 32'h99; step(); idle();
        rst = 1;
        #1 chk("s6_we_gated", {31'd0, rf_we}, 32'd0);
        step();
        chk("s6_busy", busy, 32'd0);
        rst = 0; step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = 5'($urandom_range(0, 7));
            iss_ra1   = 5'($urandom_range(0, 7));
            iss_ra2   = 5'($urandom_range(0, 7));
            alu_valid = $urandom_range(0, 1);
            alu_wa    = 5'($urandom_range(0, 7));
            alu_wd    = $urandom;
            mem_valid = $urandom_range(0, 1);
            mem_wa    = 5'($urandom_range(0, 7));
            mem_wd    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
